// File: rtl/sys_rst_sequencer.sv
// -----------------------------------------------------------------------------
// sys_rst_sequencer
//
// Sequences the resets for the system clock domain. The block waits for the
// PLL to report lock for a qualified number of cycles, then releases the
// downstream reset stages one at a time in a fixed order: clock
// infrastructure first, then datapath, then CPU/control. Once all stages are
// released and a final gap has elapsed, ready goes high.
//
// A loss of lock during release, software reset or normal running asserts
// every stage again and is counted. A software reset request in RUN holds all
// stages for a fixed time and then replays the release sequence without
// re-qualifying the PLL.
//
// Ports:
//   clk            system clock (PLL output after BUFG)
//   rst            asynchronous active-high board reset
//   pll_locked     PLL lock indication, asynchronous to clk
//   sw_rst_req     single-cycle software reset request (clk domain)
//   rst_stage      active-high staged resets, bit 0 releases first
//   ready          all stages released and the final gap elapsed
//   lock_loss_cnt  saturating count of qualified lock losses
//   state          current FSM state, for a debug CSR
// -----------------------------------------------------------------------------
module sys_rst_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int N_STAGES        = 3,
  parameter int STAGE_GAP       = 16,
  parameter int SW_RST_CYC      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                sw_rst_req,
  output logic [N_STAGES-1:0] rst_stage,
  output logic                ready,
  output logic [7:0]          lock_loss_cnt,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_STABLE  = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_SW_RST  = 3'd4
  } state_t;

  // One shared counter serves the lock qualification, the inter-stage gaps
  // and the software reset hold, so it is sized for the longest of the three.
  localparam int CNT_MAX_A = (LOCK_STABLE_CYC > STAGE_GAP) ? LOCK_STABLE_CYC : STAGE_GAP;
  localparam int CNT_MAX   = (CNT_MAX_A > SW_RST_CYC) ? CNT_MAX_A : SW_RST_CYC;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_RST_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_STAGES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_STAGES-1:0] rst_stage_d;
  logic                ready_d;
  logic [7:0]          loss_cnt_d;

  logic [SYNC_STAGES-1:0] pll_sync;
  logic [1:0]             rst_sync;
  logic                   locked_s;
  logic                   rst_done;

  // NOTE: the synchronizer flops are async-reset to 0 so that a board reset
  // always forces "not locked" and the sequence restarts from scratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_sync <= '0;
      rst_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its neighbour; blocking here would collapse the chain.
      pll_sync <= {pll_sync[SYNC_STAGES-2:0], pll_locked};
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign locked_s = pll_sync[SYNC_STAGES-1];
  assign rst_done = rst_sync[1];

  // Reset pattern while stages 0..idx are released: only the higher stages
  // stay asserted, which keeps the release order monotonic by construction.
  function automatic logic [N_STAGES-1:0] held_mask(input logic [IDX_W-1:0] idx);
    logic [N_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      m[i] = (i > int'(idx));
    end
    return m;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  always_comb begin
    // NOTE: every target gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_stage_d = rst_stage;
    ready_d     = ready;
    loss_cnt_d  = lock_loss_cnt;

    case (state_q)
      S_HOLD: begin
        rst_stage_d = '1;
        ready_d     = 1'b0;
        if (rst_done && locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end
      end

      S_STABLE: begin
        rst_stage_d = '1;
        ready_d     = 1'b0;
        if (!locked_s) begin
          // Acquisition glitch: start over, not counted as a loss.
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d     = S_RELEASE;
          cnt_d       = '0;
          idx_d       = '0;
          rst_stage_d = held_mask('0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RELEASE: begin
        if (!locked_s) begin
          state_d     = S_HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          rst_stage_d = '1;
          ready_d     = 1'b0;
          loss_cnt_d  = sat_inc(lock_loss_cnt);
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d     = S_RUN;
            rst_stage_d = '0;
            ready_d     = 1'b1;
          end else begin
            idx_d       = idx_q + 1'b1;
            rst_stage_d = held_mask(idx_q + 1'b1);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // Lock loss is checked first so it wins over a coincident request.
        if (!locked_s) begin
          state_d     = S_HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          rst_stage_d = '1;
          ready_d     = 1'b0;
          loss_cnt_d  = sat_inc(lock_loss_cnt);
        end else if (sw_rst_req) begin
          state_d     = S_SW_RST;
          cnt_d       = '0;
          rst_stage_d = '1;
          ready_d     = 1'b0;
        end
      end

      S_SW_RST: begin
        if (!locked_s) begin
          state_d     = S_HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          rst_stage_d = '1;
          ready_d     = 1'b0;
          loss_cnt_d  = sat_inc(lock_loss_cnt);
        end else if (cnt_q == SW_LAST) begin
          state_d     = S_RELEASE;
          cnt_d       = '0;
          idx_d       = '0;
          rst_stage_d = held_mask('0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = S_HOLD;
        cnt_d       = '0;
        idx_d       = '0;
        rst_stage_d = '1;
        ready_d     = 1'b0;
      end
    endcase
  end

  // Outputs come straight from flops so rst_stage cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      rst_stage     <= '1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      rst_stage     <= rst_stage_d;
      ready         <= ready_d;
      lock_loss_cnt <= loss_cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_sys_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sys_rst_sequencer
//
// Directed bench for sys_rst_sequencer with small timing parameters. A table
// of {inputs, hold cycles, expected outputs} records walks through cold
// start, software reset, lock loss, acquisition glitch and collision cases;
// hand-written loops cover counter saturation and an asynchronous reset in
// the middle of the release sequence. Stage ordering is watched every cycle.
// -----------------------------------------------------------------------------
module tb_sys_rst_sequencer;

  localparam int SYNC_STAGES     = 2;
  localparam int LOCK_STABLE_CYC = 8;
  localparam int N_STAGES        = 3;
  localparam int STAGE_GAP       = 4;
  localparam int SW_RST_CYC      = 5;

  localparam logic [2:0] HOLD    = 3'd0;
  localparam logic [2:0] STABLE  = 3'd1;
  localparam logic [2:0] RELEASE = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] SW_RST  = 3'd4;

  logic                clk;
  logic                rst;
  logic                pll_locked;
  logic                sw_rst_req;
  logic [N_STAGES-1:0] rst_stage;
  logic                ready;
  logic [7:0]          lock_loss_cnt;
  logic [2:0]          state;

  int vectors;
  int miscompares;

  sys_rst_sequencer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
    .N_STAGES       (N_STAGES),
    .STAGE_GAP      (STAGE_GAP),
    .SW_RST_CYC     (SW_RST_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
    .rst_stage    (rst_stage),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned cycles;
    logic        pll;
    logic        sw;
    logic [2:0]  stage;
    logic        rdy;
    logic [7:0]  cnt;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input int unsigned c, input logic p,
                              input logic s, input logic [2:0] stg, input logic r,
                              input logic [7:0] cnt, input logic [2:0] st);
    vec_t v;
    v.name   = n;
    v.cycles = c;
    v.pll    = p;
    v.sw     = s;
    v.stage  = stg;
    v.rdy    = r;
    v.cnt    = cnt;
    v.st     = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [2:0] stg, input logic r,
                           input logic [7:0] cnt, input logic [2:0] st);
    check({name, ".rst_stage"}, 32'(rst_stage), 32'(stg));
    check({name, ".ready"}, 32'(ready), 32'(r));
    check({name, ".lock_loss_cnt"}, 32'(lock_loss_cnt), 32'(cnt));
    check({name, ".state"}, 32'(state), 32'(st));
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the active edge.
  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A released stage must never have an earlier stage still in reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      logic ordered;
      ordered = 1'b1;
      for (int k = 1; k < N_STAGES; k++) begin
        if (!rst_stage[k] && rst_stage[k-1]) ordered = 1'b0;
      end
      check("stage_order", 32'(ordered), 32'd1);
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    pll_locked  = 1'b0;
    sw_rst_req  = 1'b0;

    // Cold start: 10 cycles qualification window, then 4-cycle gaps.
    tbl.push_back(mk("cold_wait",    10, 1, 0, 3'b111, 0, 0, STABLE));
    tbl.push_back(mk("cold_s0",       1, 1, 0, 3'b110, 0, 0, RELEASE));
    tbl.push_back(mk("cold_s0_hold",  3, 1, 0, 3'b110, 0, 0, RELEASE));
    tbl.push_back(mk("cold_s1",       1, 1, 0, 3'b100, 0, 0, RELEASE));
    tbl.push_back(mk("cold_s2",       4, 1, 0, 3'b000, 0, 0, RELEASE));
    tbl.push_back(mk("cold_pre_rdy",  3, 1, 0, 3'b000, 0, 0, RELEASE));
    tbl.push_back(mk("cold_rdy",      1, 1, 0, 3'b000, 1, 0, RUN));
    // Software reset: 5 cycles all asserted, then the staged release.
    tbl.push_back(mk("sw_req",        1, 1, 1, 3'b111, 0, 0, SW_RST));
    tbl.push_back(mk("sw_hold",       4, 1, 0, 3'b111, 0, 0, SW_RST));
    tbl.push_back(mk("sw_s0",         1, 1, 0, 3'b110, 0, 0, RELEASE));
    tbl.push_back(mk("sw_s1",         4, 1, 0, 3'b100, 0, 0, RELEASE));
    tbl.push_back(mk("sw_s2",         4, 1, 0, 3'b000, 0, 0, RELEASE));
    tbl.push_back(mk("sw_rdy",        4, 1, 0, 3'b000, 1, 0, RUN));
    // Lock loss in RUN: two synchronizer cycles, then reset on the third.
    tbl.push_back(mk("loss_sync",     2, 0, 0, 3'b000, 1, 0, RUN));
    tbl.push_back(mk("loss_hit",      1, 0, 0, 3'b111, 0, 1, HOLD));
    tbl.push_back(mk("hold_sw_req",   1, 0, 1, 3'b111, 0, 1, HOLD));
    tbl.push_back(mk("hold_sw_idle",  3, 0, 0, 3'b111, 0, 1, HOLD));
    // Re-lock replays the cold-start timing.
    tbl.push_back(mk("relock_wait",  10, 1, 0, 3'b111, 0, 1, STABLE));
    tbl.push_back(mk("relock_s0",     1, 1, 0, 3'b110, 0, 1, RELEASE));
    tbl.push_back(mk("relock_s1",     4, 1, 0, 3'b100, 0, 1, RELEASE));
    tbl.push_back(mk("relock_s2",     4, 1, 0, 3'b000, 0, 1, RELEASE));
    tbl.push_back(mk("relock_rdy",    4, 1, 0, 3'b000, 1, 1, RUN));
    // Second loss, then an acquisition glitch that must not be counted.
    tbl.push_back(mk("loss2",         3, 0, 0, 3'b111, 0, 2, HOLD));
    tbl.push_back(mk("glitch_hi",     5, 1, 0, 3'b111, 0, 2, STABLE));
    tbl.push_back(mk("glitch_lo",     3, 0, 0, 3'b111, 0, 2, HOLD));
    tbl.push_back(mk("glitch_rehi",  10, 1, 0, 3'b111, 0, 2, STABLE));
    tbl.push_back(mk("glitch_s0",     1, 1, 0, 3'b110, 0, 2, RELEASE));
    tbl.push_back(mk("glitch_s1",     4, 1, 0, 3'b100, 0, 2, RELEASE));
    tbl.push_back(mk("glitch_s2",     4, 1, 0, 3'b000, 0, 2, RELEASE));
    tbl.push_back(mk("glitch_rdy",    4, 1, 0, 3'b000, 1, 2, RUN));
    // sw_rst_req on the same cycle the FSM sees the loss: loss wins.
    tbl.push_back(mk("coll_sync",     2, 0, 0, 3'b000, 1, 2, RUN));
    tbl.push_back(mk("coll_hit",      1, 0, 1, 3'b111, 0, 3, HOLD));
    tbl.push_back(mk("coll_after",    1, 0, 0, 3'b111, 0, 3, HOLD));

    // Board reset is asserted asynchronously before the first clock edge.
    #1 rst = 1'b1;
    #1;
    check_all("reset_async", 3'b111, 1'b0, 8'd0, HOLD);
    tick(3);
    check_all("reset_held", 3'b111, 1'b0, 8'd0, HOLD);
    rst = 1'b0;
    tick(4);
    check_all("idle_hold", 3'b111, 1'b0, 8'd0, HOLD);

    foreach (tbl[i]) begin
      pll_locked = tbl[i].pll;
      sw_rst_req = tbl[i].sw;
      tick(tbl[i].cycles);
      check_all(tbl[i].name, tbl[i].stage, tbl[i].rdy, tbl[i].cnt, tbl[i].st);
    end
    sw_rst_req = 1'b0;

    // Qualified losses during RELEASE until the counter pins at 255
    // (three losses already counted above).
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      tick(11);
      if (i == 0) check("sat_release_state", 32'(state), 32'(RELEASE));
      pll_locked = 1'b0;
      tick(3);
      if (i == 250) check("sat_254", 32'(lock_loss_cnt), 32'd254);
      if (i == 251) check("sat_255", 32'(lock_loss_cnt), 32'd255);
    end
    check_all("sat_final", 3'b111, 1'b0, 8'd255, HOLD);

    // Async reset after stage 0 has been released, checked before any edge.
    pll_locked = 1'b1;
    tick(12);
    check_all("arst_pre", 3'b110, 1'b0, 8'd255, RELEASE);
    #2 rst = 1'b1;
    #1;
    check_all("arst_hit", 3'b111, 1'b0, 8'd0, HOLD);
    tick(2);
    rst = 1'b0;
    tick(10);
    check_all("arst_requal", 3'b111, 1'b0, 8'd0, STABLE);
    tick(1);
    check_all("arst_s0", 3'b110, 1'b0, 8'd0, RELEASE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Backstop so the run always ends, even if the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sys_rst_sequencer.md
Name: sys_rst_sequencer

Overview:
Consumer end of the system PLL. Takes the asynchronous PLL lock indication and produces glitch-free, staged reset releases for the 80 MHz system clock domain.
Downstream blocks come out of reset in a fixed order: clock infrastructure, then datapath, then CPU/control.
Lock loss re-asserts all resets and is counted. A software reset request replays the release sequence without waiting for PLL re-qualification.

Parameters:
SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2)
LOCK_STABLE_CYC, 1024, consecutive synchronized-locked cycles required before the first release
N_STAGES, 3, number of staged reset outputs
STAGE_GAP, 16, cycles between successive stage releases, and from the last stage release to ready
SW_RST_CYC, 32, cycles all stages are held asserted on a software reset

Ports:
clk  in  1  system clock (PLL output after BUFG)
rst  in  1  asynchronous active-high reset (board reset)
pll_locked  in  1  PLL lock, asynchronous to clk
sw_rst_req  in  1  single-cycle software reset request, clk domain
rst_stage  out  N_STAGES  active-high resets; bit 0 releases first
ready  out  1  all stages released and STAGE_GAP elapsed
lock_loss_cnt  out  8  saturating count of qualified lock losses
state  out  3  FSM state, for debug CSR

Behaviour:
- Reset (rst=1), asserted asynchronously:
  - rst_stage = all ones, ready=0, lock_loss_cnt=0, state=HOLD, all counters 0, synchronizer flops 0.
  - rst deassertion is synchronized internally through 2 flops; the FSM leaves HOLD no earlier than 2 cycles after rst falls.
- pll_locked passes through SYNC_STAGES flops; locked_s denotes the synchronizer output. No other logic samples pll_locked.
- All outputs are registered; rst_stage bits never glitch.
- HOLD (0):
  - all stages asserted.
  - locked_s=1 -> STABLE, stable counter = 0.
- STABLE (1):
  - counter increments each cycle while locked_s=1.
  - locked_s=0 -> HOLD, counter cleared, loss NOT counted (acquisition glitch).
  - counter = LOCK_STABLE_CYC-1 -> RELEASE, stage index 0, gap counter 0.
- RELEASE (2):
  - rst_stage[0] clears on the first RELEASE cycle.
  - rst_stage[k] clears STAGE_GAP cycles after rst_stage[k-1].
  - STAGE_GAP cycles after the last stage clears -> RUN, ready=1.
  - Absolute timing: rst_stage[0] falls SYNC_STAGES+LOCK_STABLE_CYC+1 cycles after pll_locked rises (clean synchronizer capture).
- RUN (3):
  - ready=1, rst_stage=0.
  - locked_s=0 -> on the next edge: rst_stage=all ones, ready=0, lock_loss_cnt += 1 (saturates at 255), state -> HOLD.
  - sw_rst_req=1 -> SW_RST, rst_stage=all ones, ready=0, counter 0.
  - Simultaneous lock loss and sw_rst_req: lock loss wins and is counted.
- SW_RST (4):
  - all stages held asserted for SW_RST_CYC cycles, then -> RELEASE (STABLE is skipped).
- Lock loss in RELEASE or SW_RST:
  - same action as in RUN (all asserted, count, -> HOLD).
- sw_rst_req outside RUN is ignored, with no queuing.
- Mid-sequence rst assertion: immediate async return to reset values; lock_loss_cnt clears.
- Unused state encodings (5-7) -> HOLD with all stages asserted.
- Stage monotonicity invariant: at every cycle, rst_stage[k]=0 implies rst_stage[k-1]=0.

Test Plan:
Parameters for all scenarios: SYNC_STAGES=2, LOCK_STABLE_CYC=8, N_STAGES=3, STAGE_GAP=4, SW_RST_CYC=5.
1. Cold start: rst released, pll_locked rises at cycle 0 -> rst_stage[0] falls at cycle 11, [1] at 15, [2] at 19; ready=1 at 23; lock_loss_cnt=0.
2. Acquisition glitch: pll_locked high 5 cycles, low 3 cycles, then high -> no stage releases early; sequence restarts from the final rise (stage0 falls 11 cycles later); lock_loss_cnt stays 0.
3. Lock loss in RUN: pll_locked falls -> rst_stage=3'b111 and ready=0 within 3 cycles; lock_loss_cnt=1; re-lock replays the full case-1 timing.
4. Software reset: 1-cycle sw_rst_req in RUN -> rst_stage=3'b111 for 5 cycles, then stage0 falls, [1] 4 cycles later, [2] 4 cycles after that; ready 4 cycles after [2]; lock_loss_cnt unchanged. A sw_rst_req pulsed during HOLD has no effect.
5. Collisions and saturation: sw_rst_req coincident with lock loss -> HOLD, lock_loss_cnt increments. After 300 qualified lock losses, lock_loss_cnt=255.
6. Async rst during RELEASE, after stage0 has fallen -> rst_stage=3'b111, ready=0, lock_loss_cnt=0 without a clock edge. The stage monotonicity assertion holds throughout all scenarios.
